// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronised rx, mid-bit sampling, stop-bit check, and a
// one-entry valid/ready holding register with frame and overrun error pulses.
module uart_rx_byte #(
  parameter int CLK_FREQ    = 10000000,
  parameter int BAUD_RATE   = 115200,
  parameter int BIT_PERIOD  = 87,
  parameter int HALF_PERIOD = 43
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       busy
);

  if (BIT_PERIOD >= 65535 || HALF_PERIOD >= BIT_PERIOD || BAUD_RATE <= 0 ||
      CLK_FREQ < 2 * BAUD_RATE) begin : g_bad_cfg
    $error("uart_rx_byte: invalid timing parameters");
  end

  localparam logic [15:0] BIT_LAST  = 16'(BIT_PERIOD);
  localparam logic [15:0] HALF_LAST = 16'(HALF_PERIOD);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_WAITHI = 3'd4
  } state_t;

  state_t      state, state_next;
  logic        rx_meta, rxs;
  logic [15:0] cnt, cnt_next;
  logic [2:0]  idx, idx_next;
  logic [7:0]  shift, shift_next;
  logic        stop_ok, stop_bad;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Frame state, bit timing and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 16'd0;
      idx   <= 3'd0;
      shift <= 8'h00;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      shift <= shift_next;
    end
  end

  // Next-state logic; stop_ok/stop_bad flag the stop-bit sample cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    shift_next = shift;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_next = 16'd0;
        if (!rxs) begin
          state_next = S_START;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_START: begin
        if (cnt == HALF_LAST) begin
          cnt_next = 16'd0;
          idx_next = 3'd0;
          if (rxs) begin
            state_next = S_IDLE;
          end else begin
            state_next = S_DATA;
          end
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      S_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_next          = 16'd0;
          shift_next[idx]   = rxs;
          if (idx == 3'd7) begin
            state_next = S_STOP;
          end else begin
            idx_next = idx + 3'd1;
          end
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      S_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_next = 16'd0;
          if (rxs) begin
            stop_ok    = 1'b1;
            state_next = S_IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = S_WAITHI;
          end
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      // A held-low line must return high before a new start can be seen.
      S_WAITHI: begin
        if (rxs) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_WAITHI;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = 16'd0;
      end
    endcase
  end

  // Holding register and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out    <= 8'h00;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_err   <= stop_bad;
      overrun_err <= stop_ok & data_valid & ~data_ready;
      busy        <= (state_next != S_IDLE);
      if (stop_ok && (!data_valid || data_ready)) begin
        data_out   <= shift;
        data_valid <= 1'b1;
      end else if (stop_ok) begin
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end else begin
        data_valid <= data_valid;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: serial frames are generated at the bit
// level and received bytes are scored against a queue of expected bytes.
module tb_uart_rx_byte;

  localparam int BIT_CYC = 88;
  localparam int CLK_T   = 10;
  // Edges from the rx start edge to the commit edge: 2 sync + 1 detect +
  // (HALF+1) start + 9 bit periods, minus one to land in the stop-sample cycle.
  localparam int COMMIT_PREV = 2 + 1 + 44 + 9 * BIT_CYC - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, frame_err, overrun_err, busy;

  int checks = 0, errors = 0;
  int got_cnt = 0, extra_cnt = 0, fe_cnt = 0, ov_cnt = 0, pulse_viol = 0;
  logic [7:0] exp_q[$];

  uart_rx_byte dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .frame_err(frame_err), .overrun_err(overrun_err), .busy(busy)
  );

  always #(CLK_T / 2) clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Serial frame: start, 8 data LSB first, stop; inner edges displaced by up to +-jit cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int jit);
    int   edge_t[11];
    logic lvl[10];
    edge_t[0]  = 0;
    edge_t[10] = 10 * BIT_CYC;
    for (int k = 1; k < 10; k++) begin
      edge_t[k] = k * BIT_CYC;
      if (jit > 0) edge_t[k] += int'($urandom_range(2 * jit, 0)) - jit;
    end
    lvl[0] = 1'b0;
    for (int i = 0; i < 8; i++) lvl[i + 1] = b[i];
    lvl[9] = stop_bit;
    for (int k = 0; k < 10; k++) begin
      rx = lvl[k];
      #((edge_t[k + 1] - edge_t[k]) * CLK_T);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #3;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_data"}, 32'(data_out), 32'h00);
    check_value({tag, "_valid"}, 32'(data_valid), 32'd0);
    check_value({tag, "_fe"}, 32'(frame_err), 32'd0);
    check_value({tag, "_ov"}, 32'(overrun_err), 32'd0);
    check_value({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Monitor: one transfer per cycle with valid&ready; error pulses counted and policed.
  initial begin
    logic fe_prev, ov_prev;
    logic [7:0] e;
    fe_prev = 1'b0;
    ov_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (data_valid && data_ready) begin
        got_cnt++;
        if (exp_q.size() == 0) begin
          extra_cnt++;
        end else begin
          e = exp_q.pop_front();
          check_value("byte", 32'(data_out), 32'(e));
        end
      end
      if (frame_err) fe_cnt++;
      if (overrun_err) ov_cnt++;
      if ((frame_err && fe_prev) || (overrun_err && ov_prev) || (frame_err && overrun_err))
        pulse_viol++;
      fe_prev = frame_err;
      ov_prev = overrun_err;
    end
  end

  initial begin
    string msg;
    int    g0, f0, o0;
    logic [7:0] b;
    msg = "Philip Mohr";

    repeat (3) @(posedge clk);
    #3;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    idle(5);

    // 1: back-to-back message, always ready
    data_ready = 1'b1;
    g0 = got_cnt; f0 = fe_cnt; o0 = ov_cnt;
    for (int i = 0; i < msg.len(); i++) exp_q.push_back(msg[i]);
    align();
    for (int i = 0; i < msg.len(); i++) send_frame(msg[i], 1'b1, 0);
    idle(20);
    check_value("msg_count", 32'(got_cnt - g0), 32'd11);
    check_value("msg_q_empty", 32'(exp_q.size()), 32'd0);
    check_value("msg_fe", 32'(fe_cnt - f0), 32'd0);
    check_value("msg_ov", 32'(ov_cnt - o0), 32'd0);

    // 2: short low glitch aborts in START
    g0 = got_cnt; f0 = fe_cnt;
    align();
    rx = 1'b0;
    idle(10);
    check_value("glitch_busy", 32'(busy), 32'd1);
    idle(10);
    rx = 1'b1;
    idle(40);
    check_value("glitch_idle", 32'(busy), 32'd0);
    idle(100);
    check_value("glitch_nobyte", 32'(got_cnt - g0), 32'd0);
    check_value("glitch_nofe", 32'(fe_cnt - f0), 32'd0);

    // 3: bad stop bit, line held low, then recovery
    g0 = got_cnt; f0 = fe_cnt;
    align();
    send_frame(8'hA5, 1'b0, 0);
    idle(300);
    check_value("brk_fe", 32'(fe_cnt - f0), 32'd1);
    check_value("brk_waithi", 32'(busy), 32'd1);
    check_value("brk_nobyte", 32'(got_cnt - g0), 32'd0);
    rx = 1'b1;
    idle(10);
    check_value("brk_idle", 32'(busy), 32'd0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 0);
    idle(20);
    check_value("brk_q_empty", 32'(exp_q.size()), 32'd0);
    check_value("brk_fe_once", 32'(fe_cnt - f0), 32'd1);

    // 4: overrun while holding register is full
    data_ready = 1'b0;
    g0 = got_cnt; o0 = ov_cnt;
    align();
    send_frame(8'h68, 1'b1, 0);
    send_frame(8'h69, 1'b1, 0);
    idle(20);
    check_value("ovr_data", 32'(data_out), 32'h68);
    check_value("ovr_valid", 32'(data_valid), 32'd1);
    check_value("ovr_pulse", 32'(ov_cnt - o0), 32'd1);
    exp_q.push_back(8'h68);
    @(posedge clk); #2 data_ready = 1'b1;
    @(posedge clk); #2 data_ready = 1'b0;
    idle(2);
    check_value("ovr_cleared", 32'(data_valid), 32'd0);
    check_value("ovr_q_empty", 32'(exp_q.size()), 32'd0);

    // 5: consume old byte exactly on the commit edge of the next one
    align();
    send_frame(8'h11, 1'b1, 0);
    idle(10);
    check_value("swap_hold", 32'(data_out), 32'h11);
    exp_q.push_back(8'h11);
    o0 = ov_cnt;
    align();
    fork
      send_frame(8'h22, 1'b1, 0);
      begin
        repeat (COMMIT_PREV) @(posedge clk);
        #2 data_ready = 1'b1;
        @(posedge clk);
        #2 data_ready = 1'b0;
      end
    join
    idle(5);
    check_value("swap_data", 32'(data_out), 32'h22);
    check_value("swap_valid", 32'(data_valid), 32'd1);
    check_value("swap_no_ov", 32'(ov_cnt - o0), 32'd0);
    check_value("swap_q_empty", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(8'h22);
    @(posedge clk); #2 data_ready = 1'b1;
    @(posedge clk); #2 data_ready = 1'b0;
    idle(2);

    // 6: reset during data bit 4, then clean and jittered frames
    g0 = got_cnt; f0 = fe_cnt; o0 = ov_cnt;
    align();
    fork
      send_frame(8'hF0, 1'b1, 0);
      begin
        repeat (480) @(posedge clk);
        #4 rst_n = 1'b0;
        #2;
        check_reset_outputs("midrst");
        repeat (3) @(posedge clk);
        #4 rst_n = 1'b1;
      end
    join
    idle(10);
    check_value("midrst_nobyte", 32'(got_cnt - g0), 32'd0);
    check_value("midrst_nofe", 32'(fe_cnt - f0), 32'd0);
    data_ready = 1'b1;
    exp_q.push_back(8'h72);
    send_frame(8'h72, 1'b1, 0);
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(255, 0));
      exp_q.push_back(b);
      send_frame(b, 1'b1, 20);
    end
    idle(20);
    check_value("jit_count", 32'(got_cnt - g0), 32'd9);
    check_value("jit_q_empty", 32'(exp_q.size()), 32'd0);
    check_value("jit_no_err", 32'((fe_cnt - f0) + (ov_cnt - o0)), 32'd0);
    check_value("pulse_rules", 32'(pulse_viol), 32'd0);
    check_value("no_extra", 32'(extra_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
